// File: rtl/pdm_capture_ctrl.sv
// PDM capture sequencer: settle-sample discard, burst capture into a FWFT FIFO, watermark/done irq.
// Define PDM_CAPTURE_TRIGGER_EN to insert the ARMED state (sound-activated capture on |pcm_in| >= thresh).
module pdm_capture_ctrl #(
    parameter int DEPTH = 8,
    parameter int DW    = 16,
    parameter int CNTW  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CNTW-1:0]        settle_n,
    input  logic [CNTW-1:0]        burst_n,
    input  logic [$clog2(DEPTH):0] watermark,
    input  logic [DW-1:0]          thresh,
    input  logic [DW-1:0]          pcm_in,
    input  logic                   pcm_valid,
    input  logic                   rd_en,
    output logic                   pdm_enable,
    output logic [DW-1:0]          rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

`ifdef PDM_CAPTURE_TRIGGER_EN
    typedef enum logic [1:0] {IDLE, SETTLE, ARMED, CAPTURE} state_t;
    localparam state_t RUN_ENTRY = ARMED;
`else
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;
    localparam state_t RUN_ENTRY = CAPTURE;
`endif

    state_t          state_reg;
    logic [CNTW-1:0] settle_reg;
    logic [CNTW-1:0] burst_reg;
    logic [CNTW-1:0] cap_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [LW-1:0]   level_reg;
    logic            done_reg;
    logic            overflow_reg;
    logic            pdm_enable_reg;
    logic            busy_reg;
    logic [DW-1:0]   mem [DEPTH];

    logic            pop;
    logic            full;
    logic            take;
    logic            push;
    logic            drop;
    logic            burst_hit;
    logic [CNTW-1:0] cap_inc;

`ifdef PDM_CAPTURE_TRIGGER_EN
    logic [DW-1:0] mag;
    // Two's-complement magnitude; the most negative code saturates to the positive maximum.
    assign mag = !pcm_in[DW-1] ? pcm_in :
                 (pcm_in == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}} :
                 (~pcm_in + 1'b1);
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
`endif

    always_comb begin
        pop  = rd_en && (level_reg != '0);
        full = (level_reg == LW'(DEPTH));
        take = 1'b0;
        if (pcm_valid && !abort) begin
            if (state_reg == CAPTURE) take = 1'b1;
`ifdef PDM_CAPTURE_TRIGGER_EN
            if (state_reg == ARMED && mag >= thresh) take = 1'b1;
`endif
        end
        // A full FIFO still accepts the sample when a pop frees the slot in the same cycle.
        push      = take && (!full || pop);
        drop      = take && full && !pop;
        cap_inc   = (cap_reg == '1) ? cap_reg : cap_reg + 1'b1;
        burst_hit = take && (burst_reg != '0) && (cap_inc == burst_reg);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= pcm_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            settle_reg     <= '0;
            burst_reg      <= '0;
            cap_reg        <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            pdm_enable_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_reg + LW'(push) - LW'(pop);
            if (drop) overflow_reg <= 1'b1;
            if (take) cap_reg <= cap_inc;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        settle_reg     <= settle_n;
                        burst_reg      <= burst_n;
                        cap_reg        <= '0;
                        done_reg       <= 1'b0;
                        overflow_reg   <= 1'b0;
                        pdm_enable_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= (settle_n != '0) ? SETTLE : RUN_ENTRY;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_reg      <= IDLE;
                        pdm_enable_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                    end else if (pcm_valid) begin
                        settle_reg <= settle_reg - 1'b1;
                        if (settle_reg == CNTW'(1)) state_reg <= RUN_ENTRY;
                    end
                end
`ifdef PDM_CAPTURE_TRIGGER_EN
                ARMED: begin
                    if (abort || burst_hit) begin
                        state_reg      <= IDLE;
                        pdm_enable_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        if (!abort) done_reg <= 1'b1;
                    end else if (take) begin
                        state_reg <= CAPTURE;
                    end
                end
`endif
                CAPTURE: begin
                    if (abort || burst_hit) begin
                        state_reg      <= IDLE;
                        pdm_enable_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        if (!abort) done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    pdm_enable_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data    = (level_reg == '0) ? '0 : mem[rd_ptr_reg];
    assign level      = level_reg;
    assign pdm_enable = pdm_enable_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign overflow   = overflow_reg;
    assign irq        = done_reg | ((watermark != '0) && (level_reg >= watermark));
endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Self-checking bench for pdm_capture_ctrl: queue-based behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pdm_capture_ctrl;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int CNTW  = 8;
    localparam int LW    = 4;
`ifdef PDM_CAPTURE_TRIGGER_EN
    localparam bit TRIG = 1'b1;
`else
    localparam bit TRIG = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [CNTW-1:0] settle_n = '0;
    logic [CNTW-1:0] burst_n = '0;
    logic [LW-1:0]   watermark = '0;
    logic [DW-1:0]   thresh = '0;
    logic [DW-1:0]   pcm_in = '0;
    logic            pcm_valid = 1'b0;
    logic            rd_en = 1'b0;
    logic            pdm_enable;
    logic [DW-1:0]   rd_data;
    logic [LW-1:0]   level;
    logic            busy;
    logic            done;
    logic            overflow;
    logic            irq;

    always #5 clk = ~clk;

    pdm_capture_ctrl #(.DEPTH(DEPTH), .DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .settle_n(settle_n), .burst_n(burst_n), .watermark(watermark),
        .thresh(thresh), .pcm_in(pcm_in), .pcm_valid(pcm_valid), .rd_en(rd_en),
        .pdm_enable(pdm_enable), .rd_data(rd_data), .level(level), .busy(busy),
        .done(done), .overflow(overflow), .irq(irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 settling, 2 waiting for trigger, 3 capturing.
    int            m_phase, m_settle_left, m_burst, m_captured;
    logic [DW-1:0] m_fifo[$];
    bit            m_done, m_ovf;
    bit            model_ok = 1'b0;

    always @(posedge clk) begin
        bit do_pop, do_take;
        int v, mag;
        if (!rst_n) begin
            m_phase = 0; m_settle_left = 0; m_burst = 0; m_captured = 0;
            m_fifo.delete(); m_done = 0; m_ovf = 0; model_ok = 1'b1;
        end else begin
            do_pop  = rd_en && (m_fifo.size() > 0);
            do_take = 0;
            if (m_phase == 0) begin
                if (start) begin
                    m_settle_left = int'(settle_n); m_burst = int'(burst_n);
                    m_captured = 0; m_done = 0; m_ovf = 0;
                    m_phase = (settle_n != 0) ? 1 : (TRIG ? 2 : 3);
                end
            end else if (abort) begin
                m_phase = 0;
            end else if (pcm_valid) begin
                if (m_phase == 1) begin
                    m_settle_left--;
                    if (m_settle_left == 0) m_phase = TRIG ? 2 : 3;
                end else if (m_phase == 2) begin
                    v   = int'($signed(pcm_in));
                    mag = (v < 0) ? -v : v;
                    if (mag > 32767) mag = 32767;
                    do_take = (mag >= int'(thresh));
                end else begin
                    do_take = 1;
                end
            end
            if (do_pop) void'(m_fifo.pop_front());
            if (do_take) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(pcm_in);
                else m_ovf = 1;
                if (m_captured < 255) m_captured++;
                if (m_burst != 0 && m_captured == m_burst) begin
                    m_phase = 0; m_done = 1;
                end else begin
                    m_phase = 3;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [DW-1:0] head;
        bit            exp_irq;
        if (model_ok) begin
            head    = (m_fifo.size() > 0) ? m_fifo[0] : '0;
            exp_irq = m_done || (watermark != 0 && m_fifo.size() >= int'(watermark));
            chk("model.pdm_enable", 32'(pdm_enable), 32'(m_phase != 0));
            chk("model.busy",       32'(busy),       32'(m_phase != 0));
            chk("model.level",      32'(level),      32'(m_fifo.size()));
            chk("model.rd_data",    32'(rd_data),    32'(head));
            chk("model.done",       32'(done),       32'(m_done));
            chk("model.overflow",   32'(overflow),   32'(m_ovf));
            chk("model.irq",        32'(irq),        32'(exp_irq));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [DW-1:0] v);
        pcm_in = v; pcm_valid = 1'b1;
        tick();
        pcm_valid = 1'b0;
    endtask

    task automatic go(input logic [CNTW-1:0] s, input logic [CNTW-1:0] b, input logic [LW-1:0] w);
        settle_n = s; burst_n = b; watermark = w; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pop_check(input string nm, input logic [DW-1:0] e);
        chk(nm, 32'(rd_data), 32'(e));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("reset.pdm_enable", 32'(pdm_enable), 32'd0);
        chk("reset.level",      32'(level),      32'd0);
        chk("reset.rd_data",    32'(rd_data),    32'd0);
        chk("reset.irq",        32'(irq),        32'd0);

        // Strobes and abort while idle do nothing.
        for (int i = 0; i < 3; i++) begin sample(DW'(50 + i)); tick(); end
        abort = 1'b1; tick(); abort = 1'b0;
        chk("idle.level", 32'(level), 32'd0);
        chk("idle.pdm_enable", 32'(pdm_enable), 32'd0);

        // Settle 3, burst 4: samples 4..7 kept, 8 ignored.
        go(8'd3, 8'd4, 4'd0);
        for (int i = 1; i <= 8; i++) begin
            sample(DW'(i));
            if (i == 6) chk("burst.enable_before_end", 32'(pdm_enable), 32'd1);
            if (i == 7) begin
                chk("burst.enable_falls", 32'(pdm_enable), 32'd0);
                chk("burst.done", 32'(done), 32'd1);
                chk("burst.irq", 32'(irq), 32'd1);
            end
            tick();
        end
        chk("burst.level", 32'(level), 32'd4);
        for (int i = 4; i <= 7; i++) pop_check("burst.data", DW'(i));
        chk("burst.drained_level", 32'(level), 32'd0);

        // Burst 12 into an 8-deep FIFO with no reads.
        go(8'd0, 8'd12, 4'd0);
        for (int i = 1; i <= 12; i++) sample(DW'(100 + i));
        tick();
        chk("ovf.level", 32'(level), 32'd8);
        chk("ovf.overflow", 32'(overflow), 32'd1);
        chk("ovf.done", 32'(done), 32'd1);
        for (int i = 1; i <= 8; i++) pop_check("ovf.data", DW'(100 + i));
        chk("ovf.empty_level", 32'(level), 32'd0);
        chk("ovf.empty_data", 32'(rd_data), 32'd0);

        // Continuous capture with watermark 4.
        go(8'd0, 8'd0, 4'd4);
        for (int i = 1; i <= 3; i++) sample(DW'(200 + i));
        chk("wm.irq_below", 32'(irq), 32'd0);
        sample(DW'(204));
        chk("wm.irq_at", 32'(irq), 32'd1);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("wm.irq_after_pop", 32'(irq), 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("wm.abort_busy", 32'(busy), 32'd0);
        chk("wm.abort_level", 32'(level), 32'd3);
        chk("wm.abort_head", 32'(rd_data), 32'd202);

        // start and abort together in idle: start wins.
        abort = 1'b1;
        go(8'd0, 8'd0, 4'd0);
        abort = 1'b0;
        chk("startwins.busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 5; i++) sample(DW'(300 + i));
        chk("full.level", 32'(level), 32'd8);
        pcm_in = DW'(399); pcm_valid = 1'b1; rd_en = 1'b1;
        tick();
        pcm_valid = 1'b0; rd_en = 1'b0;
        chk("full.pushpop_level", 32'(level), 32'd8);
        chk("full.pushpop_ovf", 32'(overflow), 32'd0);
        pop_check("full.data", DW'(203));
        pop_check("full.data", DW'(204));
        for (int i = 1; i <= 5; i++) pop_check("full.data", DW'(300 + i));
        chk("full.last", 32'(rd_data), 32'd399);
        chk("full.still_busy", 32'(busy), 32'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midreset.busy", 32'(busy), 32'd0);
        chk("midreset.level", 32'(level), 32'd0);
        chk("midreset.rd_data", 32'(rd_data), 32'd0);
        tick();

`ifdef PDM_CAPTURE_TRIGGER_EN
        thresh = DW'(100);
        go(8'd0, 8'd2, 4'd0);
        sample(DW'(5)); tick();
        sample(16'hFFCE); tick();
        chk("trig.not_yet", 32'(level), 32'd0);
        sample(16'hFF9C); tick();
        sample(DW'(7)); tick();
        sample(DW'(9)); tick();
        chk("trig.level", 32'(level), 32'd2);
        chk("trig.done", 32'(done), 32'd1);
        pop_check("trig.data", 16'hFF9C);
        pop_check("trig.data", DW'(7));
        thresh = 16'h7FFF;
        go(8'd0, 8'd1, 4'd0);
        sample(16'h8000); tick();
        chk("trig.min_done", 32'(done), 32'd1);
        chk("trig.min_data", 32'(rd_data), 32'h8000);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
